// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use / data-memory-wait hazard control.
// One forwarding lane per ALU source; a small FSM drives PC/IF-ID stall, EX bubble and back-end freeze.

module hazard_forward_lane #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            hold_valid,
  input  logic [RA_W-1:0] hold_addr,
  input  logic [XLEN-1:0] hold_data,
  output logic [1:0]      sel,
  output logic [XLEN-1:0] data
);
  logic nz;
  assign nz = (rs_addr != '0);

  // Youngest producer wins: MEM, then WB, then the WB value parked during a freeze.
  always_comb begin
    sel  = 2'd0;
    data = rs_data;
    if (nz && mem_regwrite && mem_rd_addr == rs_addr) begin
      sel  = 2'd1;
      data = mem_rd_data;
    end else if (nz && wb_regwrite && wb_rd_addr == rs_addr) begin
      sel  = 2'd2;
      data = wb_rd_data;
    end else if (nz && hold_valid && hold_addr == rs_addr) begin
      sel  = 2'd3;
      data = hold_data;
    end
  end
endmodule

module hazard_forward_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  ex_rs1_addr,
  input  logic [RA_W-1:0]  ex_rs2_addr,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_alusrc_b,
  input  logic [RA_W-1:0]  ex_rd_addr,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  mem_rd_addr,
  input  logic             mem_regwrite,
  input  logic [XLEN-1:0]  mem_rd_data,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic             wb_regwrite,
  input  logic [XLEN-1:0]  wb_rd_data,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [XLEN-1:0]  store_data,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             freeze_back,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_SRC = 2;
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT} state_t;

  state_t            state;
  logic [1:0]        lu_cnt;
  logic              hold_valid;
  logic [RA_W-1:0]   hold_addr;
  logic [XLEN-1:0]   hold_data;
  logic              lu, mw;

  logic [NUM_SRC-1:0][RA_W-1:0] src_addr;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data;
  logic [NUM_SRC-1:0][1:0]      src_sel;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_data;

  assign src_addr = {ex_rs2_addr, ex_rs1_addr};
  assign src_data = {ex_rs2_data, ex_rs1_data};

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_lane
    hazard_forward_lane #(.XLEN(XLEN), .RA_W(RA_W)) u_lane (
      .rs_addr      (src_addr[g]),
      .rs_data      (src_data[g]),
      .mem_rd_addr  (mem_rd_addr),
      .mem_regwrite (mem_regwrite),
      .mem_rd_data  (mem_rd_data),
      .wb_rd_addr   (wb_rd_addr),
      .wb_regwrite  (wb_regwrite),
      .wb_rd_data   (wb_rd_data),
      .hold_valid   (hold_valid),
      .hold_addr    (hold_addr),
      .hold_data    (hold_data),
      .sel          (src_sel[g]),
      .data         (fwd_data[g])
    );
  end

  assign fwd_a_sel  = src_sel[0];
  assign fwd_b_sel  = src_sel[1];
  assign alu_a      = fwd_data[0];
  assign store_data = fwd_data[1];
  assign alu_b      = ex_alusrc_b ? ex_imm : fwd_data[1];

  assign lu = ex_memread && (ex_rd_addr != '0) &&
              ((id_rs1_used && ex_rd_addr == id_rs1_addr) ||
               (id_rs2_used && ex_rd_addr == id_rs2_addr));
  assign mw = mem_req && !mem_ready;

  // A memory wait outranks bubbling; the release cycle of MEM_WAIT drives nothing.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    freeze_back = 1'b0;
    if (mw) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      freeze_back = 1'b1;
    end else if (state == LU_WAIT || (state == RUN && lu)) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      lu_cnt     <= 2'd0;
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!freeze_back && !bubble_ex) hold_valid <= 1'b0;
      case (state)
        RUN: begin
          if (mw) begin
            state <= MEM_WAIT;
            // WB retires during the freeze while EX still needs its value.
            if (wb_regwrite && wb_rd_addr != '0) begin
              hold_valid <= 1'b1;
              hold_addr  <= wb_rd_addr;
              hold_data  <= wb_rd_data;
            end
          end else if (lu && LU_BUBBLES > 1) begin
            state  <= LU_WAIT;
            lu_cnt <= LU_INIT;
          end
        end
        LU_WAIT: begin
          if (mw) begin
            state <= MEM_WAIT;
          end else begin
            lu_cnt <= lu_cnt - 2'd1;
            if (lu_cnt == 2'd1) state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (!mw) state <= (lu_cnt != 2'd0) ? LU_WAIT : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
